// File: rtl/mux_n_pipe.sv
// mux_n_pipe: NUM_IN-to-1 datapath mux followed by a registered valid/ready output
// stage with a 2-entry skid buffer. Full throughput, 1-cycle latency, strict FIFO order.
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      synchronous reset, active-high (wins over flush and handshakes)
//   data_i     packed input channels, channel k = data_i[k*WIDTH +: WIDTH]
//   select_i   channel index, sampled together with valid_i
//   valid_i    upstream offers data_i/select_i
//   ready_o    block can accept this cycle (register-derived)
//   flush_i    synchronous discard of all held entries (wins over accept and pop)
//   data_o     head entry data
//   sel_err_o  head entry was captured with select_i >= NUM_IN
//   valid_o    data_o/sel_err_o valid
//   ready_i    downstream accepts the head entry
module mux_n_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 4,
   localparam int unsigned SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_IN*WIDTH-1:0] data_i,
   input  logic [SEL_W-1:0]        select_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   input  logic                    flush_i,
   output logic [WIDTH-1:0]        data_o,
   output logic                    sel_err_o,
   output logic                    valid_o,
   input  logic                    ready_i
);

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   main_data_q, main_data_d;
   logic               main_err_q, main_err_d;
   logic [WIDTH-1:0]   skid_data_q, skid_data_d;
   logic               skid_err_q, skid_err_d;

   logic [WIDTH-1:0]   mux_data;
   logic               mux_err;
   logic               accept;
   logic               pop;

   // Out-of-range selects yield zero data and a set error flag. When NUM_IN is a
   // power of two every select value matches a channel, so the flag never sets.
   always_comb begin
      mux_data = '0;
      mux_err  = 1'b1;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (select_i == SEL_W'(k)) begin
            mux_data = data_i[k*WIDTH +: WIDTH];
            mux_err  = 1'b0;
         end
      end
   end

   assign valid_o   = (state_q != StEmpty);
   assign ready_o   = (state_q != StTwo);
   assign data_o    = main_data_q;
   assign sel_err_o = main_err_q;

   assign accept = valid_i & ready_o & ~flush_i;
   assign pop    = valid_o & ready_i;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_err_d  = main_err_q;
      skid_data_d = skid_data_q;
      skid_err_d  = skid_err_q;

      case (state_q)
         StEmpty: begin
            if (accept) begin
               main_data_d = mux_data;
               main_err_d  = mux_err;
               state_d     = StOne;
            end
         end
         StOne: begin
            if (accept && pop) begin
               main_data_d = mux_data;
               main_err_d  = mux_err;
            end else if (accept) begin
               // Head is stalled: park the new entry behind it.
               skid_data_d = mux_data;
               skid_err_d  = mux_err;
               state_d     = StTwo;
            end else if (pop) begin
               state_d = StEmpty;
            end
         end
         StTwo: begin
            if (pop) begin
               main_data_d = skid_data_q;
               main_err_d  = skid_err_q;
               state_d     = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase

      // Data registers are left stale; only occupancy is discarded.
      if (flush_i) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StEmpty;
         main_data_q <= '0;
         main_err_q  <= 1'b0;
         skid_data_q <= '0;
         skid_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_err_q  <= main_err_d;
         skid_data_q <= skid_data_d;
         skid_err_q  <= skid_err_d;
      end
   end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: two instances (NUM_IN=4 and NUM_IN=3) share handshake
// stimulus; a queue-based reference model predicts both outputs every cycle.
module tb_mux_n_pipe;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid;
   logic         ready_in;
   logic         flush;
   logic [4*W-1:0] data;
   logic [1:0]   sel;

   logic         rdy4, err4, vout4;
   logic [W-1:0] dout4;
   logic         rdy3, err3, vout3;
   logic [W-1:0] dout3;

   always #5 clk = ~clk;

   mux_n_pipe #(.WIDTH(W), .NUM_IN(4)) u_dut4 (
      .clk_i     (clk),
      .rst_i     (rst),
      .data_i    (data),
      .select_i  (sel),
      .valid_i   (valid),
      .ready_o   (rdy4),
      .flush_i   (flush),
      .data_o    (dout4),
      .sel_err_o (err4),
      .valid_o   (vout4),
      .ready_i   (ready_in)
   );

   mux_n_pipe #(.WIDTH(W), .NUM_IN(3)) u_dut3 (
      .clk_i     (clk),
      .rst_i     (rst),
      .data_i    (data[3*W-1:0]),
      .select_i  (sel),
      .valid_i   (valid),
      .ready_o   (rdy3),
      .flush_i   (flush),
      .data_o    (dout3),
      .sel_err_o (err3),
      .valid_o   (vout3),
      .ready_i   (ready_in)
   );

   typedef struct {
      logic [W-1:0] d4;
      logic [W-1:0] d3;
      logic         e3;
   } ent_t;

   ent_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   clean   = 1'b0; // empty since reset with nothing accepted: data_o must read 0

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge: check outputs against the model, drive inputs, advance one
   // clock, update the model, return at the next negedge.
   task automatic step(input bit v, input logic [1:0] s, input bit r, input bit f,
                       input bit rs);
      ent_t e;
      bit   do_pop;
      bit   do_acc;
      check_eq("valid4", vout4, q.size() > 0);
      check_eq("ready4", rdy4, q.size() < 2);
      check_eq("valid3", vout3, q.size() > 0);
      check_eq("ready3", rdy3, q.size() < 2);
      if (q.size() > 0) begin
         check_eq("data4", dout4, q[0].d4);
         check_eq("err4", err4, 1'b0);
         check_eq("data3", dout3, q[0].d3);
         check_eq("err3", err3, q[0].e3);
      end else if (clean) begin
         check_eq("rst_data4", dout4, 0);
         check_eq("rst_err3", err3, 1'b0);
      end
      valid    = v;
      sel      = s;
      ready_in = r;
      flush    = f;
      rst      = rs;
      @(posedge clk);
      if (rs) begin
         q.delete();
         clean = 1'b1;
      end else if (f) begin
         q.delete();
      end else begin
         do_pop = (q.size() > 0) && r;
         do_acc = v && (q.size() < 2);
         if (do_pop) void'(q.pop_front());
         if (do_acc) begin
            e.d4 = data[int'(s)*W +: W];
            e.d3 = (s < 3) ? data[int'(s)*W +: W] : '0;
            e.e3 = (s == 3);
            q.push_back(e);
            clean = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      data     = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      sel      = '0;
      valid    = 1'b0;
      ready_in = 1'b0;
      flush    = 1'b0;
      rst      = 1'b1;
      repeat (2) @(posedge clk);
      q.delete();
      clean = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // 1: single transfer, 1-cycle latency
      step(1, 2, 1, 0, 0);
      check_eq("t1_data", dout4, 32'hA2);
      check_eq("t1_valid", vout4, 1'b1);
      step(0, 0, 1, 0, 0);

      // 2: back-to-back stream at full throughput
      for (int i = 0; i < 4; i++) step(1, 2'(i), 1, 0, 0);
      check_eq("t2_last", dout4, 32'hA3);
      step(0, 0, 1, 0, 0);

      // 3: stall fills the skid, then drains in order
      step(1, 1, 0, 0, 0);
      step(1, 3, 0, 0, 0);
      check_eq("t3_ready", rdy4, 1'b0);
      check_eq("t3_hold", dout4, 32'hA1);
      step(0, 0, 0, 0, 0);
      check_eq("t3_stable", dout4, 32'hA1);
      step(0, 0, 1, 0, 0);
      check_eq("t3_second", dout4, 32'hA3);
      step(0, 0, 1, 0, 0);
      check_eq("t3_ready_back", rdy4, 1'b1);

      // 4: out-of-range select on NUM_IN=3, flag not sticky
      step(1, 3, 1, 0, 0);
      check_eq("t4_err", err3, 1'b1);
      check_eq("t4_zero", dout3, 0);
      step(1, 1, 1, 0, 0);
      check_eq("t4_clear", err3, 1'b0);
      check_eq("t4_data", dout3, 32'hA1);
      step(0, 0, 1, 0, 0);

      // 5: flush from TWO with an offered word
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 2, 0, 1, 0);
      check_eq("t5_valid", vout4, 1'b0);
      check_eq("t5_ready", rdy4, 1'b1);
      repeat (3) step(0, 0, 1, 0, 0);

      // 6: reset mid-stream with valid asserted
      step(1, 0, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      step(1, 2, 1, 0, 1);
      check_eq("t6_valid", vout4, 1'b0);
      check_eq("t6_data", dout4, 0);
      check_eq("t6_ready", rdy4, 1'b1);
      repeat (3) step(0, 0, 1, 0, 0);

      // Randomized traffic with stalls, flushes and occasional resets
      for (int i = 0; i < 3000; i++) begin
         data = {$urandom(), $urandom(), $urandom(), $urandom()};
         step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
              $urandom_range(0, 127) == 0);
      end
      step(0, 0, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
